// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete combinationally; read misses stall while the FSM fills from memory.
module data_cache #(
   parameter int LINES       = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_address,
   input  logic [31:0] cpu_writedata,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic [31:0] cpu_readdata,
   output logic        cpu_ready,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   output logic        mem_writemem,
   output logic        mem_readmem,
   input  logic [31:0] mem_readdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [1:0]  fsm_state
);

   localparam int IDX = $clog2(LINES);
   localparam int TW  = 32 - IDX;
   localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

   // Handshake: a request (cpu_read or cpu_write, write wins) is held stable until
   // the cycle cpu_ready=1; that cycle completes it and the next cycle may start another.
   state_t            state, next_state;
   logic [CW-1:0]     wait_cnt;
   logic [LINES-1:0]  valid;
   logic [TW-1:0]     tag_mem  [LINES];
   logic [31:0]       data_mem [LINES];

   logic [IDX-1:0]    idx;
   logic [TW-1:0]     addr_tag;
   logic              hit;
   logic              hit_inc, miss_inc, fill_done;

   assign idx           = cpu_address[IDX-1:0];
   assign addr_tag      = cpu_address[31:IDX];
   assign hit           = valid[idx] && (tag_mem[idx] == addr_tag);
   assign mem_address   = cpu_address;
   assign mem_writedata = cpu_writedata;
   assign fsm_state     = state;

   always_comb begin
      next_state   = state;
      cpu_ready    = 1'b0;
      cpu_readdata = 32'd0;
      mem_readmem  = 1'b0;
      mem_writemem = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      fill_done    = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_write) begin
               next_state = WRITE;
            end else if (cpu_read) begin
               if (hit) begin
                  cpu_ready    = 1'b1;
                  cpu_readdata = data_mem[idx];
                  hit_inc      = 1'b1;
               end else begin
                  next_state = FILL;
                  miss_inc   = 1'b1;
               end
            end
         end
         FILL: begin
            mem_readmem = 1'b1;
            if (wait_cnt == '0) begin
               fill_done  = 1'b1;
               next_state = IDLE;
            end
         end
         WRITE: begin
            mem_writemem = 1'b1;
            cpu_ready    = 1'b1;
            hit_inc      = hit;
            miss_inc     = !hit;
            next_state   = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         valid      <= '0;
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == FILL)
            wait_cnt <= CW'(MEM_LATENCY - 1);
         else if (state == FILL && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
         if (fill_done)
            valid[idx] <= 1'b1;
         if (hit_inc && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (miss_inc && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end

   // Tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[idx] <= mem_readdata;
         tag_mem[idx]  <= addr_tag;
      end else if (state == WRITE && hit) begin
         data_mem[idx] <= cpu_writedata;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: one instance with MEM_LATENCY=1 for the main
// functional vectors and one with MEM_LATENCY=3 for the reset-during-fill case.
module tb_data_cache;

   logic        clk;
   logic        rst_a, rst_b;
   logic [31:0] cpu_address, cpu_writedata;
   logic        cpu_read, cpu_write;
   logic        sel;

   logic [31:0] rdata_a, rdata_b, maddr_a, maddr_b, mwdata_a, mwdata_b;
   logic        ready_a, ready_b, wmem_a, wmem_b, rmem_a, rmem_b;
   logic [31:0] mrdata_a, mrdata_b, hits_a, hits_b, miss_a, miss_b;
   logic [1:0]  st_a, st_b;

   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];

   int checks = 0;
   int errors = 0;

   data_cache #(.LINES(32), .MEM_LATENCY(1)) u_dut_a (
      .clk(clk), .rst(rst_a),
      .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
      .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_readdata(rdata_a), .cpu_ready(ready_a),
      .mem_address(maddr_a), .mem_writedata(mwdata_a),
      .mem_writemem(wmem_a), .mem_readmem(rmem_a), .mem_readdata(mrdata_a),
      .hit_count(hits_a), .miss_count(miss_a), .fsm_state(st_a)
   );

   data_cache #(.LINES(32), .MEM_LATENCY(3)) u_dut_b (
      .clk(clk), .rst(rst_b),
      .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
      .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_readdata(rdata_b), .cpu_ready(ready_b),
      .mem_address(maddr_b), .mem_writedata(mwdata_b),
      .mem_writemem(wmem_b), .mem_readmem(rmem_b), .mem_readdata(mrdata_b),
      .hit_count(hits_b), .miss_count(miss_b), .fsm_state(st_b)
   );

   // ---------------- clock / memory models ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mrdata_a = rmem_a ? mem_a[maddr_a[5:0]] : 32'd0;
   assign mrdata_b = rmem_b ? mem_b[maddr_b[5:0]] : 32'd0;

   always @(posedge clk) begin
      if (wmem_a) mem_a[maddr_a[5:0]] <= mwdata_a;
      if (wmem_b) mem_b[maddr_b[5:0]] <= mwdata_b;
   end

   logic [31:0] s_rdata, s_hits, s_miss;
   logic        s_ready, s_wmem, s_rmem;
   logic [1:0]  s_st;
   assign s_rdata = sel ? rdata_b : rdata_a;
   assign s_hits  = sel ? hits_b  : hits_a;
   assign s_miss  = sel ? miss_b  : miss_a;
   assign s_ready = sel ? ready_b : ready_a;
   assign s_wmem  = sel ? wmem_b  : wmem_a;
   assign s_rmem  = sel ? rmem_b  : rmem_a;
   assign s_st    = sel ? st_b    : st_a;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge; returns at a negedge with the request dropped.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input int exp_lat, input string tag);
      int lat;
      int rm;
      cpu_address = addr;
      cpu_read    = 1'b1;
      cpu_write   = 1'b0;
      lat = 0;
      rm  = 0;
      #1;
      while (!s_ready && lat < 40) begin
         if (s_rmem) rm++;
         @(negedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_readmem_cycles"}, 32'(rm), (exp_lat == 0) ? 32'd0 : 32'(exp_lat - 1));
      check({tag, "_data"}, s_rdata, exp_data);
      check({tag, "_no_wstrobe"}, {31'd0, s_wmem}, 32'd0);
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic also_read, input string tag);
      cpu_address   = addr;
      cpu_writedata = data;
      cpu_write     = 1'b1;
      cpu_read      = also_read;
      #1;
      check({tag, "_req_ready"}, {31'd0, s_ready}, 32'd0);
      check({tag, "_req_strobe"}, {31'd0, s_wmem}, 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
      check({tag, "_strobe"}, {31'd0, s_wmem}, 32'd1);
      check({tag, "_rdata_zero"}, s_rdata, 32'd0);
      @(negedge clk);
      cpu_write = 1'b0;
      cpu_read  = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = 32'd0;
         mem_b[i] = 32'd0;
      end
      mem_a[0]  = 32'd1;
      mem_a[8]  = 32'd4;
      mem_a[40] = 32'd9;
      mem_b[3]  = 32'h55;
      sel = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      cpu_address = 32'd0;
      cpu_writedata = 32'd0;
      cpu_read = 1'b0;
      cpu_write = 1'b0;

      repeat (2) @(negedge clk);
      cpu_read = 1'b1;
      #1;
      check("rst_ready", {31'd0, s_ready}, 32'd0);
      check("rst_readmem", {31'd0, s_rmem}, 32'd0);
      check("rst_writemem", {31'd0, s_wmem}, 32'd0);
      check("rst_rdata", s_rdata, 32'd0);
      check("rst_hits", s_hits, 32'd0);
      check("rst_miss", s_miss, 32'd0);
      check("rst_state", {30'd0, s_st}, 32'd0);
      cpu_read = 1'b0;
      rst_a = 1'b0;
      @(negedge clk);

      do_read(32'd0, 32'd1, 2, "rd0_miss");
      check("rd0_miss_cnt", s_miss, 32'd1);
      check("rd0_hit_cnt", s_hits, 32'd1);
      do_read(32'd0, 32'd1, 0, "rd0_hit");
      check("rd0_hit_cnt2", s_hits, 32'd2);

      do_write(32'd0, 32'h1234_5678, 1'b0, "wr0_hit");
      check("wr0_mem", mem_a[0], 32'h1234_5678);
      check("wr0_hit_cnt", s_hits, 32'd3);
      do_read(32'd0, 32'h1234_5678, 0, "rd0_after_wr");
      check("rd0_after_wr_hits", s_hits, 32'd4);

      do_write(32'd4, 32'd7, 1'b0, "wr4_miss");
      check("wr4_mem", mem_a[4], 32'd7);
      check("wr4_miss_cnt", s_miss, 32'd2);
      do_read(32'd4, 32'd7, 2, "rd4_no_alloc");
      check("rd4_miss_cnt", s_miss, 32'd3);
      check("rd4_hit_cnt", s_hits, 32'd5);

      do_read(32'd8, 32'd4, 2, "rd8_first");
      do_read(32'd40, 32'd9, 2, "rd40_alias");
      do_read(32'd8, 32'd4, 2, "rd8_evicted");
      check("alias_miss_cnt", s_miss, 32'd6);
      check("alias_hit_cnt", s_hits, 32'd8);
      #1;
      check("idle_rdata_zero", s_rdata, 32'd0);

      do_write(32'd8, 32'd5, 1'b1, "wr_wins");
      check("wr_wins_mem", mem_a[8], 32'd5);
      check("wr_wins_hits", s_hits, 32'd9);
      do_read(32'd8, 32'd5, 0, "rd8_updated");

      // Second instance: reset lands in the second FILL cycle.
      sel = 1'b1;
      rst_b = 1'b0;
      @(negedge clk);
      cpu_address = 32'd3;
      cpu_read    = 1'b1;
      #1;
      check("b_req_ready", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
      #1;
      check("b_fill1_readmem", {31'd0, s_rmem}, 32'd1);
      @(negedge clk);
      #1;
      check("b_fill2_readmem", {31'd0, s_rmem}, 32'd1);
      check("b_fill_miss", s_miss, 32'd1);
      rst_b = 1'b1;
      #1;
      check("b_rst_readmem", {31'd0, s_rmem}, 32'd0);
      check("b_rst_ready", {31'd0, s_ready}, 32'd0);
      check("b_rst_rdata", s_rdata, 32'd0);
      check("b_rst_miss", s_miss, 32'd0);
      check("b_rst_state", {30'd0, s_st}, 32'd0);
      cpu_read = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      do_read(32'd3, 32'h55, 4, "b_refill");
      check("b_refill_miss", s_miss, 32'd1);
      check("b_refill_hits", s_hits, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
